// File: rtl/sd4_mac_pkg.sv
// Shared widths and lane helpers for the SD4 MAC front end.
package sd4_mac_pkg;

  localparam int unsigned IMG_EXP_W = 4;
  localparam int unsigned IMG_MAN_W = 3;
  localparam int unsigned WGT_EXP_W = 3;
  localparam int unsigned EXP_W     = 5;
  // Helper argument width; every field is zero-extended into it.
  localparam int unsigned FN_W      = 16;

  function automatic logic is_zero_img(input logic [FN_W-1:0] mag);
    return (mag == '0);
  endfunction

  // All-ones weight exponent of width w encodes a zero weight.
  function automatic logic is_zero_wgt(input logic [FN_W-1:0] wexp, input int unsigned w);
    logic [FN_W-1:0] mask;
    mask = (FN_W'(1) << w) - FN_W'(1);
    return ((wexp & mask) == mask);
  endfunction

  function automatic logic [FN_W-1:0] pack_pp(input logic sign, input logic [FN_W-1:0] man,
                                               input int unsigned man_w);
    return (FN_W'({sign, 1'b1}) << man_w) | man;
  endfunction

  function automatic logic [FN_W-1:0] pack_exp(input logic [FN_W-1:0] img_exp,
                                                input logic [FN_W-1:0] wgt_exp);
    return img_exp + wgt_exp;
  endfunction

endpackage

// File: rtl/sd4_pp_gen.sv
// One lane: sign, zero detect, signed partial product and product exponent.
module sd4_pp_gen #(
  parameter int unsigned IMG_EXP_W = sd4_mac_pkg::IMG_EXP_W,
  parameter int unsigned IMG_MAN_W = sd4_mac_pkg::IMG_MAN_W,
  parameter int unsigned WGT_EXP_W = sd4_mac_pkg::WGT_EXP_W,
  parameter int unsigned EXP_W     = sd4_mac_pkg::EXP_W
) (
  input  logic [IMG_EXP_W+IMG_MAN_W:0] image,
  input  logic [WGT_EXP_W:0]           weight,
  output logic [IMG_MAN_W+1:0]         pp_c,
  output logic [EXP_W-1:0]             exp_c,
  output logic                         zero_c
);
  import sd4_mac_pkg::*;

  localparam int unsigned IMG_W = 1 + IMG_EXP_W + IMG_MAN_W;
  localparam int unsigned PP_W  = IMG_MAN_W + 2;

  logic                 img_sign;
  logic                 wgt_sign;
  logic [IMG_EXP_W-1:0] img_exp;
  logic [IMG_MAN_W-1:0] img_man;
  logic [WGT_EXP_W-1:0] wgt_exp;

  assign img_sign = image[IMG_W-1];
  assign img_exp  = image[IMG_MAN_W +: IMG_EXP_W];
  assign img_man  = image[IMG_MAN_W-1:0];
  assign wgt_sign = weight[WGT_EXP_W];
  assign wgt_exp  = weight[WGT_EXP_W-1:0];

  assign zero_c = is_zero_img(FN_W'(image[IMG_W-2:0])) | is_zero_wgt(FN_W'(wgt_exp), WGT_EXP_W);
  assign pp_c   = zero_c ? '0 : PP_W'(pack_pp(img_sign ^ wgt_sign, FN_W'(img_man), IMG_MAN_W));
  assign exp_c  = zero_c ? '0 : EXP_W'(pack_exp(FN_W'(img_exp), FN_W'(wgt_exp)));

endmodule

// File: rtl/sd4_pp_align_stage.sv
// SD4 MAC front stage: per-lane partial products, group max exponent and
// per-lane alignment shift, in a two-register valid/ready pipeline.
module sd4_pp_align_stage #(
  parameter int unsigned LANES     = 9,
  parameter int unsigned IMG_EXP_W = sd4_mac_pkg::IMG_EXP_W,
  parameter int unsigned IMG_MAN_W = sd4_mac_pkg::IMG_MAN_W,
  parameter int unsigned WGT_EXP_W = sd4_mac_pkg::WGT_EXP_W,
  parameter int unsigned EXP_W     = sd4_mac_pkg::EXP_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LANES*(1+IMG_EXP_W+IMG_MAN_W)-1:0] image_in,
  input  logic [LANES*(1+WGT_EXP_W)-1:0]           weight_in,
  input  logic [EXP_W-1:0]                         exp_bias_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LANES*(IMG_MAN_W+2)-1:0]           signed_pp,
  output logic [LANES*EXP_W-1:0]                   exp,
  output logic [LANES*EXP_W-1:0]                   shift,
  output logic [EXP_W-1:0]                         exp_max,
  output logic [EXP_W-1:0]                         exp_bias,
  output logic                                     all_zero
);
  localparam int unsigned IMG_W   = 1 + IMG_EXP_W + IMG_MAN_W;
  localparam int unsigned WGT_W   = 1 + WGT_EXP_W;
  localparam int unsigned PP_W    = IMG_MAN_W + 2;
  localparam int unsigned MAX_IN  = (IMG_EXP_W > WGT_EXP_W) ? IMG_EXP_W : WGT_EXP_W;
  localparam int unsigned TREE_N  = (LANES <= 1) ? 1 : (1 << $clog2(LANES));
  localparam int unsigned TREE_LV = $clog2(TREE_N);

  if (EXP_W < MAX_IN + 1) begin : g_bad_exp_w
    $error("sd4_pp_align_stage: EXP_W too narrow for the exponent sum");
  end

  logic                    s1_load;
  logic                    s2_load;
  logic [PP_W-1:0]         pp_c   [LANES];
  logic [EXP_W-1:0]        exp_c  [LANES];
  logic [LANES-1:0]        zero_c;
  logic [LANES*PP_W-1:0]   pp_flat_c;
  logic [LANES*EXP_W-1:0]  exp_flat_c;
  logic [EXP_W-1:0]        exp_max_c;
  logic [LANES*EXP_W-1:0]  shift_c;

  logic                    s1_valid;
  logic [LANES*PP_W-1:0]   s1_pp;
  logic [LANES*EXP_W-1:0]  s1_exp;
  logic [LANES-1:0]        s1_zero;
  logic [EXP_W-1:0]        s1_bias;
  logic [EXP_W-1:0]        s1_max;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sd4_pp_gen #(
      .IMG_EXP_W (IMG_EXP_W),
      .IMG_MAN_W (IMG_MAN_W),
      .WGT_EXP_W (WGT_EXP_W),
      .EXP_W     (EXP_W)
    ) u_pp_gen (
      .image  (image_in[(LANES-1-i)*IMG_W +: IMG_W]),
      .weight (weight_in[(LANES-1-i)*WGT_W +: WGT_W]),
      .pp_c   (pp_c[i]),
      .exp_c  (exp_c[i]),
      .zero_c (zero_c[i])
    );
  end

  // Lane 0 lands in the MSBs of the flat buses.
  always_comb begin
    pp_flat_c  = '0;
    exp_flat_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pp_flat_c[(LANES-1-i)*PP_W +: PP_W]    = pp_c[i];
      exp_flat_c[(LANES-1-i)*EXP_W +: EXP_W] = exp_c[i];
    end
  end

  // Max tree; zero lanes already carry exponent 0, so they never win.
  for (genvar l = 0; l <= TREE_LV; l++) begin : g_lvl
    logic [EXP_W-1:0] node [TREE_N >> l];
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < TREE_N; j++) begin : g_j
        if (j < LANES) begin : g_in
          assign node[j] = exp_c[j];
        end else begin : g_pad
          assign node[j] = '0;
        end
      end
    end else begin : g_cmp
      for (genvar k = 0; k < (TREE_N >> l); k++) begin : g_k
        assign node[k] = (g_lvl[l-1].node[2*k] > g_lvl[l-1].node[2*k+1]) ?
                         g_lvl[l-1].node[2*k] : g_lvl[l-1].node[2*k+1];
      end
    end
  end

  assign exp_max_c = g_lvl[TREE_LV].node[0];

  always_comb begin
    shift_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      shift_c[(LANES-1-i)*EXP_W +: EXP_W] =
        s1_zero[i] ? '0 : (s1_max - s1_exp[(LANES-1-i)*EXP_W +: EXP_W]);
    end
  end

  // Stage 1: lane products and group max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pp    <= '0;
      s1_exp   <= '0;
      s1_zero  <= '0;
      s1_bias  <= '0;
      s1_max   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pp   <= pp_flat_c;
        s1_exp  <= exp_flat_c;
        s1_zero <= zero_c;
        s1_bias <= exp_bias_in;
        s1_max  <= exp_max_c;
      end
    end
  end

  // Stage 2: alignment shifts; these registers are the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      signed_pp <= '0;
      exp       <= '0;
      shift     <= '0;
      exp_max   <= '0;
      exp_bias  <= '0;
      all_zero  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        signed_pp <= s1_pp;
        exp       <= s1_exp;
        shift     <= shift_c;
        exp_max   <= s1_max;
        exp_bias  <= s1_bias;
        all_zero  <= &s1_zero;
      end
    end
  end

endmodule

// File: tb/tb_sd4_pp_align_stage.sv
// Scoreboard bench for sd4_pp_align_stage: directed corner beats plus random traffic.
module tb_sd4_pp_align_stage;

  localparam int unsigned LANES     = 9;
  localparam int unsigned IMG_EXP_W = 4;
  localparam int unsigned IMG_MAN_W = 3;
  localparam int unsigned WGT_EXP_W = 3;
  localparam int unsigned EXP_W     = 5;
  localparam int unsigned IMG_W     = 1 + IMG_EXP_W + IMG_MAN_W;
  localparam int unsigned WGT_W     = 1 + WGT_EXP_W;
  localparam int unsigned PP_W      = IMG_MAN_W + 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*IMG_W-1:0]   image_in;
  logic [LANES*WGT_W-1:0]   weight_in;
  logic [EXP_W-1:0]         exp_bias_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*PP_W-1:0]    signed_pp;
  logic [LANES*EXP_W-1:0]   exp;
  logic [LANES*EXP_W-1:0]   shift;
  logic [EXP_W-1:0]         exp_max;
  logic [EXP_W-1:0]         exp_bias;
  logic                     all_zero;

  sd4_pp_align_stage #(
    .LANES(LANES), .IMG_EXP_W(IMG_EXP_W), .IMG_MAN_W(IMG_MAN_W),
    .WGT_EXP_W(WGT_EXP_W), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .image_in(image_in), .weight_in(weight_in), .exp_bias_in(exp_bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .signed_pp(signed_pp),
    .exp(exp), .shift(shift), .exp_max(exp_max), .exp_bias(exp_bias),
    .all_zero(all_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*PP_W-1:0]  pp;
    logic [LANES*EXP_W-1:0] ex;
    logic [LANES*EXP_W-1:0] sh;
    logic [EXP_W-1:0]       mx;
    logic [EXP_W-1:0]       bias;
    logic                   az;
    int                     acc_cyc;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit    lat_chk = 1'b0;
  bit    seen_full = 1'b0;

  always @(negedge clk) cyc++;

  // Reference: decode each lane arithmetically, then max and differences.
  function automatic beat_t model(input logic [LANES*IMG_W-1:0] img,
                                  input logic [LANES*WGT_W-1:0] wgt,
                                  input logic [EXP_W-1:0] bias);
    beat_t b;
    int iv, wv, sgn, ie, im, we, ppv, mx;
    int e [LANES];
    bit z [LANES];
    b.pp = '0; b.ex = '0; b.sh = '0; b.az = 1'b1; b.acc_cyc = 0;
    mx = 0;
    for (int i = 0; i < LANES; i++) begin
      iv  = int'(img[(LANES-1-i)*IMG_W +: IMG_W]);
      wv  = int'(wgt[(LANES-1-i)*WGT_W +: WGT_W]);
      sgn = (iv / (2**(IMG_W-1))) ^ (wv / (2**WGT_EXP_W));
      ie  = (iv / (2**IMG_MAN_W)) % (2**IMG_EXP_W);
      im  = iv % (2**IMG_MAN_W);
      we  = wv % (2**WGT_EXP_W);
      z[i] = ((iv % (2**(IMG_W-1))) == 0) || (we == 2**WGT_EXP_W - 1);
      ppv  = z[i] ? 0 : sgn * (2**(IMG_MAN_W+1)) + 2**IMG_MAN_W + im;
      e[i] = z[i] ? 0 : ie + we;
      if (!z[i] && e[i] > mx) mx = e[i];
      if (!z[i]) b.az = 1'b0;
      b.pp[(LANES-1-i)*PP_W +: PP_W]   = PP_W'(ppv);
      b.ex[(LANES-1-i)*EXP_W +: EXP_W] = EXP_W'(e[i]);
    end
    for (int i = 0; i < LANES; i++)
      b.sh[(LANES-1-i)*EXP_W +: EXP_W] = z[i] ? '0 : EXP_W'(mx - e[i]);
    b.mx   = EXP_W'(mx);
    b.bias = bias;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One input cycle: drive at negedge, check in_ready against occupancy, log accepts.
  task automatic drive_cycle(input bit v, input logic [LANES*IMG_W-1:0] img,
                             input logic [LANES*WGT_W-1:0] wgt, input logic [EXP_W-1:0] bias,
                             output bit acc);
    beat_t b;
    bit    exp_rdy;
    @(negedge clk);
    in_valid = v; image_in = img; weight_in = wgt; exp_bias_in = bias;
    #1;
    exp_rdy = (sb_q.size() < 2) || out_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (!in_ready) seen_full = 1'b1;
    acc = v && in_ready;
    if (acc) begin
      b = model(img, wgt, bias);
      b.acc_cyc = cyc;
      sb_q.push_back(b);
    end
  endtask

  task automatic send(input logic [LANES*IMG_W-1:0] img, input logic [LANES*WGT_W-1:0] wgt,
                      input logic [EXP_W-1:0] bias);
    bit a;
    a = 1'b0;
    for (int t = 0; t < 50 && !a; t++) drive_cycle(1'b1, img, wgt, bias, a);
    if (!a) begin
      checks++; failures++;
      $display("FAIL send_timeout: got in_ready=%0b expected accept within 50 cycles", in_ready);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int t = 0; t < n; t++) drive_cycle(1'b0, '0, '0, '0, a);
  endtask

  task automatic wait_out();
    bit a, ok;
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      drive_cycle(1'b0, '0, '0, '0, a);
      #2;
      ok = out_valid;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_out_timeout: got out_valid=0 expected 1 within 10 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) idle(1);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [IMG_W-1:0] rand_img();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return IMG_W'(8'h80);
      2: return IMG_W'(8'h7F);
      3: return IMG_W'(8'hFF);
      default: return IMG_W'($urandom);
    endcase
  endfunction

  function automatic logic [WGT_W-1:0] rand_wgt();
    case ($urandom_range(0, 7))
      0: return {1'($urandom), {WGT_EXP_W{1'b1}}};
      1: return WGT_W'(4'h6);
      default: return WGT_W'($urandom);
    endcase
  endfunction

  // Monitor: drives out_ready, pops and compares on every output transfer.
  initial begin
    bit prev_stall;
    logic [LANES*(PP_W+2*EXP_W)+2*EXP_W:0] saved;
    beat_t b;
    prev_stall = 1'b0;
    saved = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (!out_valid || {signed_pp, exp, shift, exp_max, exp_bias, all_zero} !== saved) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   out_valid, {signed_pp, exp, shift, exp_max, exp_bias, all_zero}, saved);
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_beat: got out_valid=1 expected no pending beat");
        end else begin
          b = sb_q.pop_front();
          chk("signed_pp", 64'(signed_pp), 64'(b.pp));
          chk("exp",       64'(exp),       64'(b.ex));
          chk("shift",     64'(shift),     64'(b.sh));
          chk("exp_max",   64'(exp_max),   64'(b.mx));
          chk("exp_bias",  64'(exp_bias),  64'(b.bias));
          chk("all_zero",  64'(all_zero),  64'(b.az));
          if (lat_chk) chk("latency", 64'(cyc - b.acc_cyc), 64'd2);
        end
      end
      prev_stall = out_valid && !out_ready;
      saved = {signed_pp, exp, shift, exp_max, exp_bias, all_zero};
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*IMG_W-1:0] img;
    logic [LANES*WGT_W-1:0] wgt;
    bit a;
    int n_acc;

    rst = 1'b1; in_valid = 1'b0; image_in = '0; weight_in = '0; exp_bias_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_signed_pp", 64'(signed_pp), 64'd0);
    chk("rst_exp_shift", 64'(exp | shift), 64'd0);
    chk("rst_max_bias_az", 64'({exp_max, exp_bias, all_zero}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single non-zero lane 0.
    lat_chk = 1'b1;
    img = '0; wgt = '0;
    img[(LANES-1)*IMG_W +: IMG_W] = IMG_W'(8'h1A);
    wgt[(LANES-1)*WGT_W +: WGT_W] = WGT_W'(4'h2);
    send(img, wgt, EXP_W'(5'd9));
    wait_out();
    chk("t1_pp0",    64'(signed_pp[(LANES-1)*PP_W +: PP_W]), 64'(5'b01010));
    chk("t1_exp0",   64'(exp[(LANES-1)*EXP_W +: EXP_W]), 64'd5);
    chk("t1_expmax", 64'(exp_max), 64'd5);
    chk("t1_shift0", 64'(shift[(LANES-1)*EXP_W +: EXP_W]), 64'd0);
    chk("t1_allz",   64'(all_zero), 64'd0);

    // Negative-zero images everywhere.
    for (int i = 0; i < LANES; i++) begin
      img[i*IMG_W +: IMG_W] = IMG_W'(8'h80);
      wgt[i*WGT_W +: WGT_W] = WGT_W'($urandom);
    end
    send(img, wgt, EXP_W'(5'd3));
    wait_out();
    chk("t2_pp",     64'(signed_pp), 64'd0);
    chk("t2_exp",    64'(exp | shift), 64'd0);
    chk("t2_expmax", 64'(exp_max), 64'd0);
    chk("t2_allz",   64'(all_zero), 64'd1);

    // Max exponent, min exponent and a zero-weight lane together.
    img = '0; wgt = '0;
    img[(LANES-1-3)*IMG_W +: IMG_W] = IMG_W'(8'h7F);
    wgt[(LANES-1-3)*WGT_W +: WGT_W] = WGT_W'(4'h6);
    img[(LANES-1-5)*IMG_W +: IMG_W] = IMG_W'(8'h08);
    wgt[(LANES-1-5)*WGT_W +: WGT_W] = WGT_W'(4'h0);
    img[(LANES-1-4)*IMG_W +: IMG_W] = IMG_W'(8'h55);
    wgt[(LANES-1-4)*WGT_W +: WGT_W] = WGT_W'(4'hF);
    send(img, wgt, EXP_W'(5'd31));
    wait_out();
    chk("t3_exp3",   64'(exp[(LANES-1-3)*EXP_W +: EXP_W]), 64'd21);
    chk("t3_exp5",   64'(exp[(LANES-1-5)*EXP_W +: EXP_W]), 64'd1);
    chk("t3_pp4",    64'(signed_pp[(LANES-1-4)*PP_W +: PP_W]), 64'd0);
    chk("t3_expmax", 64'(exp_max), 64'd21);
    chk("t3_shift5", 64'(shift[(LANES-1-5)*EXP_W +: EXP_W]), 64'd20);
    chk("t3_shift3", 64'(shift[(LANES-1-3)*EXP_W +: EXP_W]), 64'd0);
    chk("t3_sign3",  64'(signed_pp[(LANES-1-3)*PP_W + PP_W-1]), 64'd0);
    idle(2);

    // Six-beat stream with a five-cycle downstream stall.
    lat_chk = 1'b0;
    seen_full = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < LANES; i++) begin
        img[i*IMG_W +: IMG_W] = rand_img();
        wgt[i*WGT_W +: WGT_W] = rand_wgt();
      end
      send(img, wgt, EXP_W'(n));
      if (n == 0) begin
        rdy_mode = 2;
        fork
          begin
            repeat (5) @(posedge clk);
            rdy_mode = 0;
          end
        join_none
      end
    end
    drain();
    chk("t4_backpressure_seen", 64'(seen_full), 64'd1);

    // Async reset with two beats held.
    rdy_mode = 2;
    idle(1);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < LANES; i++) begin
        img[i*IMG_W +: IMG_W] = rand_img();
        wgt[i*WGT_W +: WGT_W] = rand_wgt();
      end
      send(img, wgt, EXP_W'(n + 20));
    end
    idle(2);
    @(negedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_pp",        64'(signed_pp), 64'd0);
    chk("t5_exp_shift", 64'(exp | shift), 64'd0);
    chk("t5_misc",      64'({exp_max, exp_bias, all_zero}), 64'd0);
    sb_q.delete();
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat_chk = 1'b1;
    img = '0; wgt = '0;
    img[(LANES-1)*IMG_W +: IMG_W] = IMG_W'(8'h1A);
    wgt[(LANES-1)*WGT_W +: WGT_W] = WGT_W'(4'h2);
    send(img, wgt, EXP_W'(5'd17));
    drain();

    // Random traffic with random valid/ready.
    lat_chk = 1'b0;
    rdy_mode = 1;
    n_acc = 0;
    for (int t = 0; t < 40000 && n_acc < 10000; t++) begin
      for (int i = 0; i < LANES; i++) begin
        img[i*IMG_W +: IMG_W] = rand_img();
        wgt[i*WGT_W +: WGT_W] = rand_wgt();
      end
      drive_cycle($urandom_range(0, 3) != 0, img, wgt, EXP_W'($urandom), a);
      if (a) n_acc++;
    end
    chk("t6_beats_sent", 64'(n_acc), 64'd10000);
    rdy_mode = 0;
    drain();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
